// File: rtl/rename_unit.sv
// Rename stage: maps source registers to a ready value or an in-flight ROB tag
// and allocates one ROB entry per accepted instruction.
module rename_unit #(
    parameter int ROB_ENTRY_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       inst_valid_ID,
    input  logic [4:0]                 rs1_ID,
    input  logic [4:0]                 rs2_ID,
    input  logic [4:0]                 rd_ID,
    input  logic                       rd_wen_ID,
    input  logic [31:0]                rf_rdata1,
    input  logic [31:0]                rf_rdata2,
    input  logic                       commit_valid,
    input  logic [4:0]                 commit_rd,
    input  logic [ROB_ENTRY_WIDTH-1:0] commit_ROB_index,
    input  logic [31:0]                commit_value,
    input  logic                       cdb_valid,
    input  logic [ROB_ENTRY_WIDTH-1:0] cdb_ROB_index,
    input  logic [31:0]                cdb_value,
    output logic [ROB_ENTRY_WIDTH-1:0] ROB_qidx_A,
    output logic [ROB_ENTRY_WIDTH-1:0] ROB_qidx_B,
    input  logic                       ROB_qready_A,
    input  logic                       ROB_qready_B,
    input  logic [31:0]                ROB_qvalue_A,
    input  logic [31:0]                ROB_qvalue_B,
    output logic [ROB_ENTRY_WIDTH-1:0] ROB_dest_RN,
    output logic [31:0]                OpAValue_RN,
    output logic [31:0]                OpBValue_RN,
    output logic [ROB_ENTRY_WIDTH-1:0] OpA_ROB_index_RN,
    output logic [ROB_ENTRY_WIDTH-1:0] OpB_ROB_index_RN,
    output logic                       alloc_RN,
    output logic                       rob_full_RN
);
    localparam int W = ROB_ENTRY_WIDTH;
    localparam logic [W-1:0] LAST  = {W{1'b1}};
    localparam logic [W-1:0] FIRST = W'(1);

    logic [W-1:0] tail_reg, tail_next;
    logic [W-1:0] count_reg, count_next;
    logic [31:0]  busy_vec;
    logic [W-1:0] tag_vec [32];
    logic         rob_full;
    logic         alloc;
    logic         rat_write;

    assign rob_full    = (count_reg == LAST);
    // Reset is folded in so nothing reports acceptance while state is held clear.
    assign alloc       = inst_valid_ID & ~stall & ~flush & ~rob_full & ~rst;
    assign rat_write   = alloc & rd_wen_ID & (rd_ID != 5'd0);
    assign rob_full_RN = rob_full;
    assign alloc_RN    = alloc;
    assign ROB_dest_RN = tail_reg;

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_rat
            if (gi == 0) begin : g_zero
                assign busy_vec[gi] = 1'b0;
                assign tag_vec[gi]  = '0;
            end else begin : g_entry
                logic         busy_reg;
                logic [W-1:0] tag_reg;
                // A rename of this register outranks a same-cycle commit of its old tag.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        busy_reg <= 1'b0;
                        tag_reg  <= '0;
                    end else if (flush) begin
                        busy_reg <= 1'b0;
                    end else if (rat_write && rd_ID == 5'(gi)) begin
                        busy_reg <= 1'b1;
                        tag_reg  <= tail_reg;
                    end else if (commit_valid && commit_rd == 5'(gi) &&
                                 tag_reg == commit_ROB_index) begin
                        busy_reg <= 1'b0;
                    end
                end
                assign busy_vec[gi] = busy_reg;
                assign tag_vec[gi]  = tag_reg;
            end
        end
    endgenerate

    function automatic logic [W+31:0] lookup(
        input logic [4:0]   rs,
        input logic         busy,
        input logic [W-1:0] tag,
        input logic [31:0]  rf_value,
        input logic         c_valid,
        input logic [W-1:0] c_index,
        input logic [31:0]  c_value,
        input logic         b_valid,
        input logic [W-1:0] b_index,
        input logic [31:0]  b_value,
        input logic         q_ready,
        input logic [31:0]  q_value
    );
        logic [W+31:0] res;
        res = '0;
        if (rs == 5'd0)                     res = '0;
        else if (!busy)                     res = {rf_value, {W{1'b0}}};
        else if (c_valid && c_index == tag) res = {c_value, {W{1'b0}}};
        else if (b_valid && b_index == tag) res = {b_value, {W{1'b0}}};
        else if (q_ready)                   res = {q_value, {W{1'b0}}};
        else                                res = {32'd0, tag};
        return res;
    endfunction

    assign ROB_qidx_A = tag_vec[rs1_ID];
    assign ROB_qidx_B = tag_vec[rs2_ID];

    assign {OpAValue_RN, OpA_ROB_index_RN} = lookup(
        rs1_ID, busy_vec[rs1_ID], tag_vec[rs1_ID], rf_rdata1,
        commit_valid, commit_ROB_index, commit_value,
        cdb_valid, cdb_ROB_index, cdb_value, ROB_qready_A, ROB_qvalue_A);

    assign {OpBValue_RN, OpB_ROB_index_RN} = lookup(
        rs2_ID, busy_vec[rs2_ID], tag_vec[rs2_ID], rf_rdata2,
        commit_valid, commit_ROB_index, commit_value,
        cdb_valid, cdb_ROB_index, cdb_value, ROB_qready_B, ROB_qvalue_B);

    // Tail skips index 0, which means "no dependency" to consumers.
    assign tail_next = (tail_reg == LAST) ? FIRST : tail_reg + W'(1);

    always_comb begin
        count_next = count_reg;
        if (flush) count_next = '0;
        else       count_next = count_reg + W'(alloc) - W'(commit_valid);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tail_reg  <= FIRST;
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
            if (flush)      tail_reg <= FIRST;
            else if (alloc) tail_reg <= tail_next;
        end
    end
endmodule

// File: tb/tb_rename_unit.sv
// Self-checking bench for rename_unit: table vectors plus model-driven
// sequences for ROB full, flush and asynchronous reset.
module tb_rename_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, inst_valid_ID, rd_wen_ID;
    logic [4:0]  rs1_ID, rs2_ID, rd_ID, commit_rd;
    logic [31:0] rf_rdata1, rf_rdata2, commit_value, cdb_value;
    logic        commit_valid, cdb_valid;
    logic [3:0]  commit_ROB_index, cdb_ROB_index;
    logic [3:0]  ROB_qidx_A, ROB_qidx_B, ROB_dest_RN;
    logic        ROB_qready_A, ROB_qready_B;
    logic [31:0] ROB_qvalue_A, ROB_qvalue_B;
    logic [31:0] OpAValue_RN, OpBValue_RN;
    logic [3:0]  OpA_ROB_index_RN, OpB_ROB_index_RN;
    logic        alloc_RN, rob_full_RN;

    always #5 clk = ~clk;

    rename_unit #(.ROB_ENTRY_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .inst_valid_ID(inst_valid_ID), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .rd_ID(rd_ID), .rd_wen_ID(rd_wen_ID),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_ROB_index(commit_ROB_index), .commit_value(commit_value),
        .cdb_valid(cdb_valid), .cdb_ROB_index(cdb_ROB_index), .cdb_value(cdb_value),
        .ROB_qidx_A(ROB_qidx_A), .ROB_qidx_B(ROB_qidx_B),
        .ROB_qready_A(ROB_qready_A), .ROB_qready_B(ROB_qready_B),
        .ROB_qvalue_A(ROB_qvalue_A), .ROB_qvalue_B(ROB_qvalue_B),
        .ROB_dest_RN(ROB_dest_RN),
        .OpAValue_RN(OpAValue_RN), .OpBValue_RN(OpBValue_RN),
        .OpA_ROB_index_RN(OpA_ROB_index_RN), .OpB_ROB_index_RN(OpB_ROB_index_RN),
        .alloc_RN(alloc_RN), .rob_full_RN(rob_full_RN)
    );

    typedef struct packed {
        logic        valid, stall, flush;
        logic [4:0]  rs1, rs2, rd;
        logic        wen;
        logic        cv;
        logic [4:0]  crd;
        logic [3:0]  cidx;
        logic [31:0] cval;
        logic        dv;
        logic [3:0]  didx;
        logic [31:0] dval;
        logic        qra;
        logic [31:0] qva;
        logic        qrb;
        logic [31:0] qvb;
        logic        e_alloc, e_full;
        logic [3:0]  e_dest, e_aidx;
        logic [31:0] e_aval;
        logic [3:0]  e_bidx;
        logic [31:0] e_bval;
        logic        e_qchk;
        logic [3:0]  e_qa, e_qb;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[10];
    int   n_vec = 0;
    int   n_bad = 0;
    int   m_tail, m_cnt;

    function automatic vec_t rn(logic valid, logic [4:0] rs1, logic [4:0] rs2,
                                logic [4:0] rd, logic wen);
        vec_t v;
        v = '0;
        v.valid = valid; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.wen = wen;
        return v;
    endfunction

    function automatic vec_t ex(vec_t vi, logic a, logic f, logic [3:0] d,
                                logic [3:0] ai, logic [31:0] av,
                                logic [3:0] bi, logic [31:0] bv);
        vec_t v;
        v = vi;
        v.e_alloc = a; v.e_full = f; v.e_dest = d;
        v.e_aidx = ai; v.e_aval = av; v.e_bidx = bi; v.e_bval = bv;
        return v;
    endfunction

    function automatic vec_t qi(vec_t vi, logic [3:0] qa, logic [3:0] qb);
        vec_t v;
        v = vi;
        v.e_qchk = 1'b1; v.e_qa = qa; v.e_qb = qb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string lbl);
        vec_t e;
        @(negedge clk);
        inst_valid_ID = v.valid; stall = v.stall; flush = v.flush;
        rs1_ID = v.rs1; rs2_ID = v.rs2; rd_ID = v.rd; rd_wen_ID = v.wen;
        rf_rdata1 = 32'hA000_0000 | 32'(v.rs1);
        rf_rdata2 = 32'hB000_0000 | 32'(v.rs2);
        commit_valid = v.cv; commit_rd = v.crd; commit_ROB_index = v.cidx; commit_value = v.cval;
        cdb_valid = v.dv; cdb_ROB_index = v.didx; cdb_value = v.dval;
        ROB_qready_A = v.qra; ROB_qvalue_A = v.qva;
        ROB_qready_B = v.qrb; ROB_qvalue_B = v.qvb;
        sb.push_back(v);
        #2;
        e = sb.pop_front();
        chk({lbl, " alloc"}, 32'(alloc_RN), 32'(e.e_alloc));
        chk({lbl, " full"},  32'(rob_full_RN), 32'(e.e_full));
        chk({lbl, " dest"},  32'(ROB_dest_RN), 32'(e.e_dest));
        chk({lbl, " a_idx"}, 32'(OpA_ROB_index_RN), 32'(e.e_aidx));
        chk({lbl, " a_val"}, OpAValue_RN, e.e_aval);
        chk({lbl, " b_idx"}, 32'(OpB_ROB_index_RN), 32'(e.e_bidx));
        chk({lbl, " b_val"}, OpBValue_RN, e.e_bval);
        if (e.e_qchk) begin
            chk({lbl, " qidx_a"}, 32'(ROB_qidx_A), 32'(e.e_qa));
            chk({lbl, " qidx_b"}, 32'(ROB_qidx_B), 32'(e.e_qb));
        end
        $display("vec %-12s alloc=%0d full=%0d dest=%0d A=%0d/%h B=%0d/%h", lbl,
                 alloc_RN, rob_full_RN, ROB_dest_RN, OpA_ROB_index_RN, OpAValue_RN,
                 OpB_ROB_index_RN, OpBValue_RN);
    endtask

    // Reference occupancy/tail model for the long sequences.
    task automatic step(input vec_t vi, input string lbl);
        vec_t v;
        logic a;
        v = vi;
        a = v.valid & ~v.stall & ~v.flush & (m_cnt != 15);
        v.e_alloc = a;
        v.e_full  = (m_cnt == 15);
        v.e_dest  = 4'(m_tail);
        apply(v, lbl);
        if (v.flush) begin
            m_tail = 1;
            m_cnt  = 0;
        end else begin
            if (a) m_tail = (m_tail == 15) ? 1 : m_tail + 1;
            m_cnt = m_cnt + int'(a) - int'(v.cv);
        end
    endtask

    initial begin
        vec_t v;
        rst = 1'b1;
        {stall, flush, inst_valid_ID, rd_wen_ID, commit_valid, cdb_valid} = '0;
        {rs1_ID, rs2_ID, rd_ID, commit_rd} = '0;
        {rf_rdata1, rf_rdata2, commit_value, cdb_value} = '0;
        {commit_ROB_index, cdb_ROB_index} = '0;
        {ROB_qready_A, ROB_qready_B, ROB_qvalue_A, ROB_qvalue_B} = '0;

        tbl[0] = ex(rn(1, 0, 0, 1, 1), 1, 0, 1, 0, 0, 0, 0);
        tbl[1] = qi(ex(rn(1, 1, 1, 2, 1), 1, 0, 2, 1, 0, 1, 0), 1, 1);
        tbl[2] = qi(ex(rn(1, 2, 7, 3, 1), 1, 0, 3, 2, 0, 0, 32'hB000_0007), 2, 0);
        v = rn(1, 3, 1, 0, 0); v.dv = 1; v.didx = 3; v.dval = 32'hDEAD_BEEF;
        tbl[3] = ex(v, 1, 0, 4, 0, 32'hDEAD_BEEF, 1, 0);
        v = rn(1, 1, 2, 5, 1); v.cv = 1; v.crd = 1; v.cidx = 1; v.cval = 32'h1234_5678;
        tbl[4] = ex(v, 1, 0, 5, 0, 32'h1234_5678, 2, 0);
        v = rn(1, 1, 5, 0, 0); v.qra = 1; v.qva = 32'h99; v.qrb = 1; v.qvb = 32'hCAFE_F00D;
        tbl[5] = qi(ex(v, 1, 0, 6, 0, 32'hA000_0001, 0, 32'hCAFE_F00D), 1, 5);
        v = rn(1, 5, 3, 6, 1); v.stall = 1;
        tbl[6] = qi(ex(v, 0, 0, 7, 5, 0, 3, 0), 5, 3);
        v = rn(1, 0, 0, 5, 1); v.cv = 1; v.crd = 5; v.cidx = 5; v.cval = 32'h55;
        tbl[7] = ex(v, 1, 0, 7, 0, 0, 0, 0);
        v = rn(1, 5, 5, 0, 0); v.cv = 1; v.crd = 5; v.cidx = 5; v.cval = 32'h66;
        tbl[8] = ex(v, 1, 0, 8, 7, 0, 7, 0);
        tbl[9] = ex(rn(1, 5, 6, 0, 0), 1, 0, 9, 7, 0, 0, 32'hB000_0006);

        // Outputs while reset is held, with a valid instruction presented.
        apply(ex(rn(1, 0, 0, 1, 1), 0, 0, 1, 0, 0, 0, 0), "in_reset");
        inst_valid_ID = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) apply(tbl[i], $sformatf("tbl%0d", i));

        m_tail = 10;
        m_cnt  = 6;
        for (int i = 0; i < 9; i++) step(rn(1, 0, 0, 0, 0), "fill");
        step(rn(1, 0, 0, 0, 0), "full_block");
        v = rn(1, 0, 0, 0, 0); v.cv = 1; v.crd = 9; v.cidx = 10;
        step(v, "full_commit");
        step(rn(1, 0, 0, 0, 0), "resume");

        v = rn(1, 0, 0, 0, 0); v.flush = 1; v.stall = 1; v.cv = 1; v.crd = 2; v.cidx = 2;
        step(v, "flush");
        v = qi(rn(1, 2, 3, 4, 1), 2, 3);
        v.e_aval = 32'hA000_0002; v.e_bval = 32'hB000_0003;
        step(v, "post_flush");
        v = rn(1, 4, 0, 0, 0); v.e_aidx = 1;
        step(v, "dep_x4");
        for (int i = 0; i < 14; i++) begin
            v = rn(1, 0, 0, 0, 0);
            if (i == 0) begin v.cv = 1; v.crd = 4; v.cidx = 1; end
            step(v, "refill");
        end
        step(rn(1, 0, 0, 0, 0), "full2");

        // Asynchronous reset between clock edges.
        #1 rst = 1'b1;
        #1;
        chk("async dest", 32'(ROB_dest_RN), 32'd1);
        chk("async full", 32'(rob_full_RN), 32'd0);
        chk("async alloc", 32'(alloc_RN), 32'd0);
        $display("vec %-12s alloc=%0d full=%0d dest=%0d", "async_rst",
                 alloc_RN, rob_full_RN, ROB_dest_RN);
        inst_valid_ID = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_tail = 1;
        m_cnt  = 0;
        v = rn(1, 2, 0, 0, 0); v.e_aval = 32'hA000_0002;
        step(v, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/rename_unit.md
# rename_unit

Rename stage of the out-of-order core. It sits between decode and the RN→DP pipeline register. Each cycle it maps one decoded instruction's source registers to either a ready value or an in-flight ROB index, and allocates the instruction's destination ROB entry. It holds the register alias table (RAT) and the ROB allocation pointer/occupancy, and it tracks commits from the ROB and results broadcast on the CDB. All data outputs are combinational from current state and inputs; state changes only on the clock edge.

## Interface
- ROB_ENTRY_WIDTH, 4, ROB index width. Index 0 is reserved as "no dependency"; usable entries are 1..2^W−1.
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- stall  in  1  downstream hold; no allocation and no RAT update this cycle
- flush  in  1  mispredict flush; ROB is flushed externally in the same cycle
- inst_valid_ID  in  1  valid instruction presented
- rs1_ID, rs2_ID, rd_ID  in  5 each  architectural registers
- rd_wen_ID  in  1  instruction writes rd
- rf_rdata1, rf_rdata2  in  32 each  register-file values for rs1/rs2
- commit_valid  in  1  ROB head retires this cycle
- commit_rd  in  5  retiring destination register
- commit_ROB_index  in  W  retiring entry
- commit_value  in  32  retiring result
- cdb_valid  in  1  CDB broadcast
- cdb_ROB_index  in  W  CDB tag
- cdb_value  in  32  CDB result
- ROB_qidx_A, ROB_qidx_B  out  W  ROB read-query index (the RAT tag for rs1/rs2)
- ROB_qready_A/B  in  1  queried entry has a finished result
- ROB_qvalue_A/B  in  32  that result
- ROB_dest_RN  out  W  allocated entry (= tail)
- OpAValue_RN, OpBValue_RN  out  32  operand value when ready, else 0
- OpA_ROB_index_RN, OpB_ROB_index_RN  out  W  0 when ready, else the producing entry
- alloc_RN  out  1  instruction accepted this cycle
- rob_full_RN  out  1  no free entry; the upstream stage must hold

## Operation
- State:
  - RAT[1..31] = {busy, tag[W]}.
  - tail pointer, W bits, range 1..2^W−1.
  - count, W bits, range 0..2^W−1.
- rob_full_RN = (count == 2^W−1).
- alloc_RN = inst_valid_ID & ~stall & ~flush & ~rob_full_RN.
- Operand lookup for each source (rs1→A, rs2→B) uses RAT state before this cycle's update. Priority:
  - rs == 0 → value 0, index 0.
  - RAT not busy → rf_rdata, index 0.
  - busy & commit_valid & commit_ROB_index == tag → commit_value, index 0.
  - busy & cdb_valid & cdb_ROB_index == tag → cdb_value, index 0.
  - busy & ROB_qready → ROB_qvalue, index 0.
  - otherwise → value 0, index = tag.
- ROB_qidx = RAT tag, regardless of busy.
- On alloc_RN:
  - tail advances; it wraps from 2^W−1 to 1 and never produces 0.
  - Every instruction allocates an entry, including stores and branches.
  - If rd_wen_ID & rd_ID ≠ 0: RAT[rd] ← {1, tail}.
- On commit_valid (processed even while stalled):
  - If RAT[commit_rd] busy and its tag equals commit_ROB_index, clear busy.
  - count decrements.
- Simultaneous commit and rename of the same rd: the rename wins, and RAT keeps the new tag.
- count next = count + alloc_RN − commit_valid, so simultaneous alloc and commit leaves count unchanged.
- Flush: at the next edge all busy bits clear, tail ← 1, count ← 0. Commits in the flush cycle are ignored.
- Reset (asynchronous): all busy bits 0, tail = 1, count = 0.
- Output values while in reset: ROB_dest_RN = 1, rob_full_RN = 0, alloc_RN = 0. Operand outputs follow the lookup rules with an empty RAT.

## Timing
- Zero-cycle combinational path from inputs to outputs. RAT, tail and count update at the rising edge of clk.
- An instruction renamed in cycle N sees the RAT writes of cycle N−1.
- Back-to-back dependent instructions are correct: the second one gets the first one's tag.
- rob_full_RN asserts in the cycle count reaches 2^W−1. It deasserts in the cycle after a commit lowers count.
- A full ROB with a same-cycle commit does not allocate; allocation resumes the next cycle.
- The pointer wrap from 15 to 1 (W=4) takes no extra cycle.
- A flush asserted together with stall still takes effect.

## Test plan
- Reset then rename addi x1 (rd_wen=1) → ROB_dest_RN=1, alloc_RN=1. Next cycle rename add x2,x1,x1 → OpA/OpB_ROB_index_RN=1, values 0, ROB_dest_RN=2.
- Rename x3 producer at tag 3. Next cycle drive cdb_valid with index 3 and value 0xDEADBEEF while renaming a reader of x3 → OpAValue_RN=0xDEADBEEF, index 0.
- Allocate 15 instructions with no commits → rob_full_RN=1 and tail wraps to 1. 16th instruction → alloc_RN=0. One commit → rob_full_RN=0 the following cycle.
- Commit x5 at tag 4 in the same cycle a new x5 writer renames at tag 9 → RAT[x5] remains busy with tag 9. A later reader gets index 9.
- Fill 6 entries with x1..x6 busy, then assert flush → the next cycle all reads return rf_rdata with index 0, ROB_dest_RN=1 and count 0.
- Assert rst asynchronously mid-stream between clock edges → state clears immediately: ROB_dest_RN=1 and rob_full_RN=0 before the next clk edge.
